alu_writeback: RTL and testbench

Writeback stage directly downstream of the ALU. Captures one ALU result per cycle under a valid/ready handshake, then commits it to the architectural state:
- the register-file write port;
- the status register;
- the stack register;
- the program-counter load port.

MULT needs two register writes, so the stage stalls upstream for exactly one cycle on MULT.

---
 rtl/alu_writeback_if.sv | 35 +++
 rtl/alu_writeback.sv | 154 +++++++++++++++
 tb/tb_alu_writeback.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_writeback_if.sv
// Bundle of signals between the ALU, the writeback stage and the architectural
// state it updates. The master is the upstream/observer side; the slave is the
// writeback stage.
interface alu_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [5:0]  encoded_opcode;
  logic [2:0]  rd_addr;
  logic [15:0] aluout1;
  logic [15:0] aluout2;
  logic [7:0]  statusregout;
  logic [11:0] decremented_stack_reg;
  logic        reg_we;
  logic [2:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic        pc_we;
  logic [11:0] pc_data;
  logic [7:0]  status_q;
  logic [11:0] stack_q;

  modport master (
    output in_valid, flush, encoded_opcode, rd_addr, aluout1, aluout2,
           statusregout, decremented_stack_reg,
    input  in_ready, reg_we, reg_waddr, reg_wdata, pc_we, pc_data,
           status_q, stack_q
  );

  modport slave (
    input  in_valid, flush, encoded_opcode, rd_addr, aluout1, aluout2,
           statusregout, decremented_stack_reg,
    output in_ready, reg_we, reg_waddr, reg_wdata, pc_we, pc_data,
           status_q, stack_q
  );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback stage: captures one ALU result per handshake and commits it to
// the register-file write port, status register, stack register and PC load
// port. MULT takes a second cycle to write the high half to rd+1.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a new result; commits of the previous accept are visible
// WB_HI | MULT low half being written; high half (rd+1) goes out next cycle
module alu_writeback #(
  parameter logic [7:0]  STATUS_RESET = 8'h00,
  parameter logic [11:0] STACK_RESET  = 12'h000
) (
  input logic         clk,
  input logic         reset_n,
  alu_writeback_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, WB_HI = 1'b1} state_t;

  typedef enum logic [2:0] {
    CLS_WRITE,
    CLS_JUMP,
    CLS_STACK_JUMP,
    CLS_NONE,
    CLS_MULT
  } op_class_t;

  state_t      state_q, state_d;
  logic        reg_we_q, reg_we_d;
  logic [2:0]  reg_waddr_q, reg_waddr_d;
  logic [15:0] reg_wdata_q, reg_wdata_d;
  logic        pc_we_q, pc_we_d;
  logic [11:0] pc_data_q, pc_data_d;
  logic [7:0]  status_reg_q, status_reg_d;
  logic [11:0] stack_reg_q, stack_reg_d;
  logic [2:0]  hi_addr_q, hi_addr_d;
  logic [15:0] hi_data_q, hi_data_d;

  op_class_t   op_class;
  logic        accept;

  assign bus.in_ready  = (state_q == IDLE);
  assign accept        = bus.in_valid & bus.in_ready & ~bus.flush;

  assign bus.reg_we    = reg_we_q;
  assign bus.reg_waddr = reg_waddr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.pc_we     = pc_we_q;
  assign bus.pc_data   = pc_data_q;
  assign bus.status_q  = status_reg_q;
  assign bus.stack_q   = stack_reg_q;

  // Sort the incoming opcode into its writeback class.
  always_comb begin
    op_class = CLS_WRITE;
    case (bus.encoded_opcode)
      6'b100001:                       op_class = CLS_MULT;
      6'b000000, 6'b100011:            op_class = CLS_JUMP;
      6'b000011, 6'b100100, 6'b100110: op_class = CLS_STACK_JUMP;
      6'b001111, 6'b010101, 6'b010110, 6'b011100,
      6'b100000, 6'b110111, 6'b111000: op_class = CLS_NONE;
      default: begin
        // flag set/clear block 101001..110110
        if ((bus.encoded_opcode >= 6'b101001) && (bus.encoded_opcode <= 6'b110110))
          op_class = CLS_NONE;
      end
    endcase
  end

  // Next-state and next-output logic; strobes default low, data holds.
  always_comb begin
    state_d      = state_q;
    reg_we_d     = 1'b0;
    reg_waddr_d  = reg_waddr_q;
    reg_wdata_d  = reg_wdata_q;
    pc_we_d      = 1'b0;
    pc_data_d    = pc_data_q;
    status_reg_d = status_reg_q;
    stack_reg_d  = stack_reg_q;
    hi_addr_d    = hi_addr_q;
    hi_data_d    = hi_data_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          status_reg_d = bus.statusregout;
          case (op_class)
            CLS_MULT: begin
              reg_we_d    = 1'b1;
              reg_waddr_d = bus.rd_addr;
              reg_wdata_d = bus.aluout1;
              hi_addr_d   = bus.rd_addr + 3'd1;
              hi_data_d   = bus.aluout2;
              state_d     = WB_HI;
            end
            CLS_JUMP: begin
              pc_we_d   = 1'b1;
              pc_data_d = bus.aluout1[11:0];
            end
            CLS_STACK_JUMP: begin
              pc_we_d     = 1'b1;
              pc_data_d   = bus.aluout1[11:0];
              stack_reg_d = bus.decremented_stack_reg;
            end
            CLS_WRITE: begin
              reg_we_d    = 1'b1;
              reg_waddr_d = bus.rd_addr;
              reg_wdata_d = bus.aluout1;
            end
            default: ;
          endcase
        end
      end
      WB_HI: begin
        // flush here only cancels the high half; the low write already happened
        state_d = IDLE;
        if (!bus.flush) begin
          reg_we_d    = 1'b1;
          reg_waddr_d = hi_addr_q;
          reg_wdata_d = hi_data_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and architectural registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      reg_we_q     <= 1'b0;
      reg_waddr_q  <= 3'd0;
      reg_wdata_q  <= 16'h0000;
      pc_we_q      <= 1'b0;
      pc_data_q    <= 12'h000;
      status_reg_q <= STATUS_RESET;
      stack_reg_q  <= STACK_RESET;
      hi_addr_q    <= 3'd0;
      hi_data_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      reg_we_q     <= reg_we_d;
      reg_waddr_q  <= reg_waddr_d;
      reg_wdata_q  <= reg_wdata_d;
      pc_we_q      <= pc_we_d;
      pc_data_q    <= pc_data_d;
      status_reg_q <= status_reg_d;
      stack_reg_q  <= stack_reg_d;
      hi_addr_q    <= hi_addr_d;
      hi_data_q    <= hi_data_d;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback. Expected register/PC writes are pushed to a
// scoreboard queue as stimulus is driven and popped when a strobe appears.
module tb_alu_writeback;

  localparam logic [7:0]  STATUS_RST = 8'hA5;
  localparam logic [11:0] STACK_RST  = 12'h3C0;

  typedef struct {
    logic        is_pc;
    logic [2:0]  addr;
    logic [15:0] data;
  } wb_t;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fails;
  wb_t  exp_q[$];
  logic [11:0] exp_stack;

  alu_writeback_if bus ();

  alu_writeback #(
    .STATUS_RESET (STATUS_RST),
    .STACK_RESET  (STACK_RST)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // 0 write, 1 jump, 2 stack-jump, 3 no write, 4 mult
  function automatic int kind_of(input logic [5:0] op);
    int k;
    case (op)
      6'b100001:                       k = 4;
      6'b000000, 6'b100011:            k = 1;
      6'b000011, 6'b100100, 6'b100110: k = 2;
      6'b001111, 6'b010101, 6'b010110, 6'b011100,
      6'b100000, 6'b110111, 6'b111000: k = 3;
      default: k = (op >= 6'd41 && op <= 6'd54) ? 3 : 0;
    endcase
    return k;
  endfunction

  task automatic push_wb(input logic is_pc, input logic [2:0] addr, input logic [15:0] data);
    wb_t e;
    e.is_pc = is_pc;
    e.addr  = addr;
    e.data  = data;
    exp_q.push_back(e);
  endtask

  // Drive an op and record every write it must produce (MULT: both halves).
  task automatic offer(input logic [5:0] op, input logic [2:0] rd, input logic [15:0] a1,
                       input logic [15:0] a2, input logic [7:0] st, input logic [11:0] sk);
    int k;
    bus.in_valid              = 1'b1;
    bus.encoded_opcode        = op;
    bus.rd_addr               = rd;
    bus.aluout1               = a1;
    bus.aluout2               = a2;
    bus.statusregout          = st;
    bus.decremented_stack_reg = sk;
    k = kind_of(op);
    case (k)
      0: push_wb(1'b0, rd, a1);
      1: push_wb(1'b1, 3'd0, {4'h0, a1[11:0]});
      2: begin
        push_wb(1'b1, 3'd0, {4'h0, a1[11:0]});
        exp_stack = sk;
      end
      4: begin
        push_wb(1'b0, rd, a1);
        push_wb(1'b0, rd + 3'd1, a2);
      end
      default: ;
    endcase
  endtask

  // Advance one clock and reconcile any strobe with the scoreboard.
  task automatic tick();
    wb_t e;
    @(posedge clk);
    #1;
    if (bus.reg_we === 1'b1 || bus.pc_we === 1'b1) begin
      check("single strobe", 32'(bus.reg_we & bus.pc_we), 32'd0);
      if (exp_q.size() == 0) begin
        check("spurious reg_we", 32'(bus.reg_we), 32'd0);
        check("spurious pc_we", 32'(bus.pc_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wb kind", 32'(bus.pc_we), 32'(e.is_pc));
        if (e.is_pc) begin
          check("pc_data", 32'(bus.pc_data), 32'(e.data));
        end else begin
          check("reg_waddr", 32'(bus.reg_waddr), 32'(e.addr));
          check("reg_wdata", 32'(bus.reg_wdata), 32'(e.data));
        end
      end
    end
  endtask

  initial begin
    logic [5:0] ops [12];
    n_checks = 0;
    n_fails  = 0;
    exp_stack = STACK_RST;
    reset_n  = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.encoded_opcode = 6'd0;
    bus.rd_addr = 3'd0;
    bus.aluout1 = 16'h0;
    bus.aluout2 = 16'h0;
    bus.statusregout = 8'h0;
    bus.decremented_stack_reg = 12'h0;
    ops = '{6'b001111, 6'b101001, 6'b110110, 6'b010101, 6'b010110, 6'b011100,
            6'b100000, 6'b110111, 6'b111000, 6'b101000, 6'b111001, 6'b000011};

    // reset state
    tick();
    tick();
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst reg_we", 32'(bus.reg_we), 32'd0);
    check("rst reg_waddr", 32'(bus.reg_waddr), 32'd0);
    check("rst reg_wdata", 32'(bus.reg_wdata), 32'd0);
    check("rst pc_we", 32'(bus.pc_we), 32'd0);
    check("rst pc_data", 32'(bus.pc_data), 32'd0);
    check("rst status", 32'(bus.status_q), 32'(STATUS_RST));
    check("rst stack", 32'(bus.stack_q), 32'(STACK_RST));
    reset_n = 1'b1;
    tick();

    // ADD
    offer(6'b010001, 3'd3, 16'h1234, 16'h0, 8'h40, 12'h777);
    tick();
    bus.in_valid = 1'b0;
    check("add reg_we", 32'(bus.reg_we), 32'd1);
    check("add status", 32'(bus.status_q), 32'h40);
    check("add pc_we", 32'(bus.pc_we), 32'd0);
    check("add in_ready", 32'(bus.in_ready), 32'd1);
    check("add stack", 32'(bus.stack_q), 32'(STACK_RST));
    tick();
    check("add strobe pulse", 32'(bus.reg_we), 32'd0);
    check("add waddr hold", 32'(bus.reg_waddr), 32'd3);

    // MULT with rd wrap 7 -> 0
    offer(6'b100001, 3'd7, 16'hBEEF, 16'h0012, 8'h55, 12'h777);
    tick();
    bus.in_valid = 1'b0;
    check("mult lo reg_we", 32'(bus.reg_we), 32'd1);
    check("mult in_ready lo", 32'(bus.in_ready), 32'd0);
    check("mult status", 32'(bus.status_q), 32'h55);
    tick();
    check("mult hi reg_we", 32'(bus.reg_we), 32'd1);
    check("mult in_ready hi", 32'(bus.in_ready), 32'd1);
    tick();
    check("mult done reg_we", 32'(bus.reg_we), 32'd0);

    // CALL
    offer(6'b100100, 3'd1, 16'h0ABC, 16'h0, 8'h12, 12'h101);
    tick();
    bus.in_valid = 1'b0;
    check("call pc_we", 32'(bus.pc_we), 32'd1);
    check("call stack", 32'(bus.stack_q), 32'h101);
    check("call reg_we", 32'(bus.reg_we), 32'd0);
    tick();
    check("call pc pulse", 32'(bus.pc_we), 32'd0);
    check("call pc_data hold", 32'(bus.pc_data), 32'hABC);

    // JMR: pc load only, stack untouched
    offer(6'b000000, 3'd2, 16'hF123, 16'h0, 8'h13, 12'h777);
    tick();
    bus.in_valid = 1'b0;
    check("jmr pc_we", 32'(bus.pc_we), 32'd1);
    check("jmr stack", 32'(bus.stack_q), 32'h101);

    // SEC flag op
    offer(6'b101101, 3'd2, 16'h9999, 16'h0, 8'h44, 12'h777);
    tick();
    bus.in_valid = 1'b0;
    check("sec status", 32'(bus.status_q), 32'h44);
    check("sec reg_we", 32'(bus.reg_we), 32'd0);
    check("sec pc_we", 32'(bus.pc_we), 32'd0);
    check("sec stack", 32'(bus.stack_q), 32'h101);

    // class boundaries, back-to-back at one op per cycle
    for (int i = 0; i < 12; i++) begin
      offer(ops[i], 3'(i), 16'h1000 + 16'(i), 16'h0, 8'h80 + 8'(i), 12'h200 + 12'(i));
      tick();
      check("loop status", 32'(bus.status_q), 32'h80 + 32'(i));
      check("loop stack", 32'(bus.stack_q), 32'(exp_stack));
    end
    bus.in_valid = 1'b0;
    tick();

    // flush in IDLE: nothing captured
    offer(6'b010001, 3'd6, 16'h6666, 16'h0, 8'h99, 12'h777);
    exp_q.pop_back();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("idle flush status", 32'(bus.status_q), 32'h8B);
    check("idle flush reg_we", 32'(bus.reg_we), 32'd0);

    // flush in WB_HI, with an ADD waiting behind the MULT
    offer(6'b100001, 3'd2, 16'hAA11, 16'hBB22, 8'h21, 12'h777);
    exp_q.pop_back();
    tick();
    check("fl lo reg_we", 32'(bus.reg_we), 32'd1);
    offer(6'b010001, 3'd5, 16'h5555, 16'h0, 8'h22, 12'h777);
    exp_q.pop_back();
    bus.flush = 1'b1;
    tick();
    check("fl hi suppressed", 32'(bus.reg_we), 32'd0);
    check("fl in_ready", 32'(bus.in_ready), 32'd1);
    check("fl status", 32'(bus.status_q), 32'h21);
    bus.flush = 1'b0;
    push_wb(1'b0, 3'd5, 16'h5555);
    tick();
    bus.in_valid = 1'b0;
    check("add after flush", 32'(bus.reg_we), 32'd1);
    check("add after flush status", 32'(bus.status_q), 32'h22);

    // MULT stalls a waiting ADD for one cycle without flush
    offer(6'b100001, 3'd0, 16'h0A0A, 16'h0B0B, 8'h31, 12'h777);
    tick();
    offer(6'b010001, 3'd4, 16'h4444, 16'h0, 8'h32, 12'h777);
    tick();
    check("stall status", 32'(bus.status_q), 32'h31);
    tick();
    bus.in_valid = 1'b0;
    check("stall add status", 32'(bus.status_q), 32'h32);

    // reset mid-MULT aborts the high write
    offer(6'b100001, 3'd4, 16'hC0DE, 16'hD00D, 8'h66, 12'h777);
    exp_q.pop_back();
    tick();
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    check("rst mid reg_we", 32'(bus.reg_we), 32'd0);
    check("rst mid pc_we", 32'(bus.pc_we), 32'd0);
    check("rst mid status", 32'(bus.status_q), 32'(STATUS_RST));
    check("rst mid stack", 32'(bus.stack_q), 32'(STACK_RST));
    check("rst mid in_ready", 32'(bus.in_ready), 32'd1);
    reset_n = 1'b1;
    tick();
    check("post rst reg_we", 32'(bus.reg_we), 32'd0);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
